// File: rtl/shift_seq_ctrl.sv
// Sequencer for a chain of 1-bit shift stages: loads a word by valid/ready, then streams it MSB first.
// Optional stall input is compiled in with SHIFT_CTRL_PAUSE_EN.
module shift_seq_ctrl #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4,
  parameter int DIV   = 1,
  parameter int DIV_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
`ifdef SHIFT_CTRL_PAUSE_EN
  input  logic             pause,
`endif
  output logic             start_ready,
  input  logic [WIDTH-1:0] data_in,
  output logic             shift,
  output logic             ser_out,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] bit_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);

  state_t           state, next_state;
  logic [WIDTH-1:0] hold, hold_d;
  logic [DIV_W-1:0] div_cnt, div_d;
  logic [CNT_W-1:0] bit_cnt_d;
  logic             start_ready_d, shift_d, ser_out_d, busy_d, done_d;
  logic             stall, handshake, last_bit;

`ifdef SHIFT_CTRL_PAUSE_EN
  assign stall = pause;
`else
  assign stall = 1'b0;
`endif

  assign handshake = (state == IDLE) && start_valid && start_ready;
  assign last_bit  = shift && (bit_cnt == CNT_FULL);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  always_comb begin
    next_state = IDLE;
    case (state)
      IDLE:    next_state = handshake ? SHIFT : IDLE;
      SHIFT:   next_state = last_bit ? DONE : SHIFT;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Every output is registered, so this block computes the values for the next cycle.
  // div_cnt always holds the in-period index of the next active cycle.
  always_comb begin
    hold_d        = hold;
    div_d         = div_cnt;
    bit_cnt_d     = bit_cnt;
    start_ready_d = 1'b0;
    shift_d       = 1'b0;
    ser_out_d     = 1'b0;
    busy_d        = 1'b0;
    done_d        = 1'b0;
    case (state)
      IDLE: begin
        if (handshake) begin
          hold_d    = data_in;
          shift_d   = (DIV_LAST == '0);
          div_d     = shift_d ? '0 : DIV_W'(1);
          bit_cnt_d = CNT_W'(shift_d);
          ser_out_d = data_in[WIDTH-1];
          busy_d    = 1'b1;
        end else begin
          start_ready_d = 1'b1;
        end
      end
      SHIFT: begin
        if (last_bit) begin
          done_d = 1'b1;
        end else begin
          busy_d = 1'b1;
          hold_d = shift ? (hold << 1) : hold;
          if (stall) begin
            ser_out_d = ser_out;
          end else begin
            ser_out_d = hold_d[WIDTH-1];
            shift_d   = (div_cnt == DIV_LAST);
            div_d     = shift_d ? '0 : div_cnt + DIV_W'(1);
            bit_cnt_d = bit_cnt + CNT_W'(shift_d);
          end
        end
      end
      DONE: begin
        start_ready_d = 1'b1;
      end
      default: begin
        hold_d = hold;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold        <= '0;
      div_cnt     <= '0;
      bit_cnt     <= '0;
      start_ready <= 1'b0;
      shift       <= 1'b0;
      ser_out     <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      hold        <= hold_d;
      div_cnt     <= div_d;
      bit_cnt     <= bit_cnt_d;
      start_ready <= start_ready_d;
      shift       <= shift_d;
      ser_out     <= ser_out_d;
      busy        <= busy_d;
      done        <= done_d;
    end
  end

endmodule
